// File: rtl/io_request_scheduler.sv
// Round-robin scheduler for the shared non-cacheable IO port.
// Runs one transaction at a time through IDLE -> ISSUE -> RESPOND.
module io_request_scheduler #(
  parameter int          NUM_REQUESTERS = 4,
  parameter int          TID_WIDTH      = 2,
  parameter logic [31:0] PERF_BASE      = 32'hffff1000,
  parameter logic [31:0] PERF_SIZE      = 32'h100,
  localparam int         RW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQUESTERS-1:0]                req_valid,
  input  logic [NUM_REQUESTERS-1:0]                req_store,
  input  logic [NUM_REQUESTERS-1:0][31:0]          req_address,
  input  logic [NUM_REQUESTERS-1:0][31:0]          req_data,
  input  logic [NUM_REQUESTERS-1:0][TID_WIDTH-1:0] req_thread,
  output logic [NUM_REQUESTERS-1:0]                req_ready,
  output logic                                     io_write_en,
  output logic                                     io_read_en,
  output logic [31:0]                              io_address,
  output logic [31:0]                              io_write_data,
  input  logic [31:0]                              io_read_data,
  output logic                                     perf_read_en,
  input  logic [31:0]                              perf_read_data,
  output logic                                     rsp_valid,
  output logic [RW-1:0]                            rsp_requester,
  output logic [TID_WIDTH-1:0]                     rsp_thread,
  output logic [31:0]                              rsp_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } state_t;

  state_t               state;
  logic [RW-1:0]        rr_last;
  logic [RW-1:0]        grant_idx;
  logic                 grant_any;
  logic [RW-1:0]        cur_req;
  logic                 cur_store;
  logic [31:0]          cur_addr;
  logic [TID_WIDTH-1:0] cur_thread;
  logic                 is_perf;
  logic                 in_issue;

  // Scan from farthest to nearest after rr_last so the nearest valid wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQUESTERS; i >= 1; i--) begin
      int idx;
      idx = (int'(rr_last) + i) % NUM_REQUESTERS;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx[RW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_last       <= RW'(NUM_REQUESTERS - 1);
      cur_req       <= '0;
      cur_store     <= 1'b0;
      cur_addr      <= '0;
      cur_thread    <= '0;
      io_address    <= '0;
      io_write_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            rr_last       <= grant_idx;
            cur_req       <= grant_idx;
            cur_store     <= req_store[grant_idx];
            cur_addr      <= req_address[grant_idx];
            cur_thread    <= req_thread[grant_idx];
            io_address    <= req_address[grant_idx];
            io_write_data <= req_data[grant_idx];
            state         <= ISSUE;
          end
        end
        ISSUE:   state <= RESPOND;
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign is_perf  = (cur_addr & ~(PERF_SIZE - 32'd1)) == PERF_BASE;
  assign in_issue = (state == ISSUE);

  // A store into the PMU window raises no strobe at all.
  assign io_write_en  = in_issue &  cur_store & ~is_perf;
  assign io_read_en   = in_issue & ~cur_store & ~is_perf;
  assign perf_read_en = in_issue & ~cur_store &  is_perf;

  assign rsp_valid     = (state == RESPOND);
  assign rsp_requester = rsp_valid ? cur_req : '0;
  assign rsp_thread    = rsp_valid ? cur_thread : '0;

  always_comb begin
    rsp_data = '0;
    if (rsp_valid && !cur_store)
      rsp_data = is_perf ? perf_read_data : io_read_data;
  end

endmodule

// File: tb/tb_io_request_scheduler.sv
// Bench for io_request_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_io_request_scheduler;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_store;
  logic [3:0][31:0] req_address;
  logic [3:0][31:0] req_data;
  logic [3:0][1:0]  req_thread;
  logic [3:0]       req_ready;
  logic             io_write_en;
  logic             io_read_en;
  logic [31:0]      io_address;
  logic [31:0]      io_write_data;
  logic [31:0]      io_read_data;
  logic             perf_read_en;
  logic [31:0]      perf_read_data;
  logic             rsp_valid;
  logic [1:0]       rsp_requester;
  logic [1:0]       rsp_thread;
  logic [31:0]      rsp_data;

  int total = 0;
  int bad   = 0;
  int m_last;

  io_request_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_store     (req_store),
    .req_address   (req_address),
    .req_data      (req_data),
    .req_thread    (req_thread),
    .req_ready     (req_ready),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .perf_read_en  (perf_read_en),
    .perf_read_data(perf_read_data),
    .rsp_valid     (rsp_valid),
    .rsp_requester (rsp_requester),
    .rsp_thread    (rsp_thread),
    .rsp_data      (rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int model_grant(logic [3:0] v, int last);
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (last + i) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit model_perf(logic [31:0] a);
    return (a >= 32'hffff1000) && (a < 32'hffff1100);
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    req_valid   = '0;
    req_store   = '0;
    req_address = '0;
    req_data    = '0;
    req_thread  = '0;
    repeat (2) tick;
    reset  = 1'b0;
    m_last = 3;
    for (int c = 0; c < 10; c++) begin
      io_read_data   = $urandom;
      perf_read_data = $urandom;
      tick;
      total++;
      if ({req_ready, io_write_en, io_read_en, perf_read_en,
           rsp_valid, rsp_requester, rsp_thread} !== 14'd0) begin
        bad++;
        $display("FAIL reset_ctrl c=%0d: got %h want 0", c,
          {req_ready, io_write_en, io_read_en, perf_read_en,
           rsp_valid, rsp_requester, rsp_thread});
      end
      total++;
      if ({io_address, io_write_data, rsp_data} !== 96'd0) begin
        bad++;
        $display("FAIL reset_data c=%0d: got %h %h %h want 0", c,
          io_address, io_write_data, rsp_data);
      end
    end
  endtask

  task automatic test_single(input int r, input bit st,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] t);
    bit          perf, ew, er, ep;
    int          n;
    logic [31:0] exp_d;
    perf = model_perf(a);
    ew   = st & ~perf;
    er   = ~st & ~perf;
    ep   = ~st & perf;
    req_valid      = '0;
    req_valid[r]   = 1'b1;
    req_store[r]   = st;
    req_address[r] = a;
    req_data[r]    = d;
    req_thread[r]  = t;
    #1;
    n = 0;
    while (req_ready == '0 && n < 8) begin
      tick;
      n++;
    end
    total++;
    if (req_ready !== 4'(1 << r)) begin
      bad++;
      $display("FAIL single_grant r=%0d: got %b want %b", r,
        req_ready, 4'(1 << r));
    end
    m_last = r;
    tick;
    req_valid = '0;
    total++;
    if ({io_write_en, io_read_en, perf_read_en} !== {ew, er, ep}) begin
      bad++;
      $display("FAIL single_strobe a=%h: got %b want %b", a,
        {io_write_en, io_read_en, perf_read_en}, {ew, er, ep});
    end
    total++;
    if (io_address !== a) begin
      bad++;
      $display("FAIL single_addr: got %h want %h", io_address, a);
    end
    if (ew) begin
      total++;
      if (io_write_data !== d) begin
        bad++;
        $display("FAIL single_wdata: got %h want %h", io_write_data, d);
      end
    end
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'd0) begin
      bad++;
      $display("FAIL single_issue_quiet: got %b %b want 0 0",
        rsp_valid, req_ready);
    end
    tick;
    io_read_data   = $urandom;
    perf_read_data = $urandom;
    #1;
    exp_d = st ? 32'd0 : (perf ? perf_read_data : io_read_data);
    total++;
    if ({rsp_valid, rsp_requester, rsp_thread, rsp_data} !==
        {1'b1, 2'(r), t, exp_d}) begin
      bad++;
      $display("FAIL single_rsp: got %b %0d %0d %h want 1 %0d %0d %h",
        rsp_valid, rsp_requester, rsp_thread, rsp_data, r, t, exp_d);
    end
    total++;
    if ({io_write_en, io_read_en, perf_read_en} !== 3'b000) begin
      bad++;
      $display("FAIL single_rsp_strobe: got %b want 000",
        {io_write_en, io_read_en, perf_read_en});
    end
    tick;
    total++;
    if (rsp_valid !== 1'b0 || io_address !== a) begin
      bad++;
      $display("FAIL single_after: got %b %h want 0 %h",
        rsp_valid, io_address, a);
    end
  endtask

  task automatic test_round_robin;
    int exp_g, last_t, grants, cyc;
    for (int i = 0; i < 4; i++) begin
      req_store[i]   = 1'b0;
      req_address[i] = 32'h100 + 32'(i * 4);
      req_thread[i]  = 2'(i);
    end
    req_valid = 4'hf;
    #1;
    last_t = -1;
    grants = 0;
    cyc    = 0;
    while (cyc < 60 && grants < 12) begin
      if (req_ready != 4'd0) begin
        exp_g = model_grant(4'hf, m_last);
        total++;
        if (req_ready !== 4'(1 << exp_g)) begin
          bad++;
          $display("FAIL rr_order: got %b want %b", req_ready,
            4'(1 << exp_g));
        end
        if (last_t >= 0) begin
          total++;
          if (cyc - last_t != 3) begin
            bad++;
            $display("FAIL rr_gap: got %0d want 3", cyc - last_t);
          end
        end
        last_t = cyc;
        m_last = exp_g;
        grants++;
      end
      tick;
      cyc++;
    end
    total++;
    if (grants != 12) begin
      bad++;
      $display("FAIL rr_count: got %0d want 12", grants);
    end
    req_valid = '0;
    repeat (3) tick;
  endtask

  task automatic test_fairness;
    int seq [3];
    int exp_seq [3];
    int n, cyc;
    exp_seq = '{0, 3, 0};
    reset = 1'b1;
    tick;
    reset  = 1'b0;
    m_last = 3;
    req_store = '0;
    req_address[0] = 32'h200;
    req_address[3] = 32'h300;
    req_valid = 4'b1001;
    #1;
    n   = 0;
    cyc = 0;
    while (n < 3 && cyc < 30) begin
      if (req_ready != 4'd0) begin
        seq[n] = (req_ready == 4'b0001) ? 0 :
                 (req_ready == 4'b1000) ? 3 : -1;
        n++;
      end
      tick;
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= n || seq[i] !== exp_seq[i]) begin
        bad++;
        $display("FAIL fair_seq[%0d]: got %0d want %0d", i,
          (i < n) ? seq[i] : -1, exp_seq[i]);
      end
    end
    m_last    = 0;
    req_valid = '0;
    repeat (3) tick;
  endtask

  task automatic test_reset_in_issue;
    int n;
    req_valid      = 4'b0100;
    req_store[2]   = 1'b0;
    req_address[2] = 32'h80;
    #1;
    n = 0;
    while (req_ready == '0 && n < 8) begin
      tick;
      n++;
    end
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL rst_issue_grant: got %b want 0100", req_ready);
    end
    tick;
    req_valid = '0;
    reset     = 1'b1;
    tick;
    reset  = 1'b0;
    m_last = 3;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({rsp_valid, io_write_en, io_read_en, perf_read_en} !== 4'd0) begin
        bad++;
        $display("FAIL rst_issue_quiet c=%0d: got %b want 0000", c,
          {rsp_valid, io_write_en, io_read_en, perf_read_en});
      end
      tick;
    end
    req_valid = 4'hf;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rst_issue_next: got %b want 0001", req_ready);
    end
    m_last = 0;
    tick;
    req_valid = '0;
    repeat (2) tick;
  endtask

  task automatic test_random;
    logic [3:0]  mask;
    int          g;
    bit          st, perf;
    logic [31:0] a, d, exp_d;
    logic [1:0]  t;
    for (int i = 0; i < 4; i++) begin
      req_store[i]   = 1'($urandom);
      req_address[i] = $urandom_range(0, 1) ?
                       {24'hffff10, 8'($urandom)} : $urandom;
      req_data[i]    = $urandom;
      req_thread[i]  = 2'($urandom);
    end
    for (int k = 0; k < 40; k++) begin
      mask      = 4'($urandom_range(1, 15));
      req_valid = mask;
      #1;
      g = model_grant(mask, m_last);
      total++;
      if (req_ready !== 4'(1 << g)) begin
        bad++;
        $display("FAIL rand_grant k=%0d: got %b want %b", k,
          req_ready, 4'(1 << g));
      end
      m_last = g;
      st   = req_store[g];
      a    = req_address[g];
      d    = req_data[g];
      t    = req_thread[g];
      perf = model_perf(a);
      tick;
      req_valid = 4'($urandom);
      req_store[g]   = 1'($urandom);
      req_address[g] = $urandom_range(0, 1) ?
                       {24'hffff10, 8'($urandom)} : $urandom;
      req_data[g]    = $urandom;
      req_thread[g]  = 2'($urandom);
      #1;
      total++;
      if ({req_ready, io_write_en, io_read_en, perf_read_en, io_address}
          !== {4'd0, st & ~perf, ~st & ~perf, ~st & perf, a}) begin
        bad++;
        $display("FAIL rand_issue k=%0d: got %b %b %h want %b %h", k,
          req_ready, {io_write_en, io_read_en, perf_read_en}, io_address,
          {st & ~perf, ~st & ~perf, ~st & perf}, a);
      end
      if (st && !perf) begin
        total++;
        if (io_write_data !== d) begin
          bad++;
          $display("FAIL rand_wdata k=%0d: got %h want %h", k,
            io_write_data, d);
        end
      end
      tick;
      io_read_data   = $urandom;
      perf_read_data = $urandom;
      #1;
      exp_d = st ? 32'd0 : (perf ? perf_read_data : io_read_data);
      total++;
      if ({req_ready, rsp_valid, rsp_requester, rsp_thread, rsp_data} !==
          {4'd0, 1'b1, 2'(g), t, exp_d}) begin
        bad++;
        $display("FAIL rand_rsp k=%0d: got %b %b %0d %0d %h want 1 %0d %0d %h",
          k, req_ready, rsp_valid, rsp_requester, rsp_thread, rsp_data,
          g, t, exp_d);
      end
      tick;
    end
    req_valid = '0;
    tick;
  endtask

  initial begin
    io_read_data   = '0;
    perf_read_data = '0;
    test_reset;
    test_single(1, 1'b0, 32'h40, 32'h0, 2'd2);
    test_single(0, 1'b0, 32'hffff1004, 32'h0, 2'd1);
    test_single(2, 1'b1, 32'h60, 32'h3, 2'd3);
    test_single(3, 1'b1, 32'hffff1000, 32'h55, 2'd0);
    test_single(1, 1'b0, 32'hffff10fc, 32'h0, 2'd1);
    test_single(0, 1'b0, 32'hffff1100, 32'h0, 2'd2);
    test_round_robin;
    test_fairness;
    test_reset_in_issue;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
